// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, line level and sizing helper.
// Imported by the tx stage and the companion rx stage.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/uart_tx_bps.sv
// UART transmitter driven by a one-cycle baud tick from the upstream divider.
// Frames are start, LSB-first data, optional parity and 1 or 2 stop bits.
module uart_tx_bps
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bps_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = cnt_width(DATA_BITS);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
  localparam logic ODD = (PARITY_ODD != 0);
  localparam logic PEN = (PARITY_EN != 0);

  uart_state_t state, state_nxt;

  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 par, par_nxt;
  logic                 txd_nxt;
  logic                 accept;

  assign accept   = tx_valid & tx_ready;
  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);

  // rst_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      par   <= 1'b0;
      txd   <= LINE_IDLE;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      par   <= par_nxt;
      txd   <= txd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (accept) state_nxt = SYNC;
      SYNC:   if (bps_tick) state_nxt = START;
      START:  if (bps_tick) state_nxt = DATA;
      DATA: begin
        if (bps_tick && cnt == LAST_DATA)
          state_nxt = PEN ? PARITY : STOP;
      end
      PARITY: if (bps_tick) state_nxt = STOP;
      STOP: begin
        if (bps_tick && cnt == LAST_STOP)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // txd_nxt is registered so every line edge lands 1 clk after a tick
  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    par_nxt   = par;
    txd_nxt   = txd;
    tx_done   = 1'b0;
    unique case (state)
      IDLE: begin
        txd_nxt = LINE_IDLE;
        if (accept) begin
          shreg_nxt = tx_data;
          par_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      end
      SYNC: begin
        if (bps_tick) txd_nxt = 1'b0;
      end
      START: begin
        if (bps_tick) begin
          txd_nxt = shreg[0];
          cnt_nxt = '0;
        end
      end
      DATA: begin
        if (bps_tick) begin
          shreg_nxt = shreg >> 1;
          par_nxt   = par ^ shreg[0];
          if (cnt == LAST_DATA) begin
            cnt_nxt = '0;
            txd_nxt = PEN ? (par ^ shreg[0] ^ ODD)
                          : LINE_IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
            txd_nxt = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bps_tick) begin
          txd_nxt = LINE_IDLE;
          cnt_nxt = '0;
        end
      end
      STOP: begin
        txd_nxt = LINE_IDLE;
        if (bps_tick) begin
          if (cnt == LAST_STOP)
            tx_done = ~rst_n;
          else
            cnt_nxt = cnt + CW'(1);
        end
      end
      default: txd_nxt = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_bps.sv
// Bench for uart_tx_bps: four parameterisations share clock, tick and data.
// Expected line bits are queued at send time and checked cycle by cycle.
module tb_uart_tx_bps;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       bps_tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] valid = 4'b0000;
  logic [3:0] ready, txd, busy, done;

  int vec = 0;
  int bad = 0;
  int tc = 0;
  bit exp_q[$];

  // inst 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
  localparam logic [3:0] PEN   = 4'b0110;
  localparam logic [3:0] PODD  = 4'b0100;
  localparam logic [3:0] STOP2 = 4'b1000;

  uart_tx_bps #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .bps_tick(bps_tick), .tx_data(tx_data),
    .tx_valid(valid[0]), .tx_ready(ready[0]), .txd(txd[0]),
    .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx_bps #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .bps_tick(bps_tick), .tx_data(tx_data),
    .tx_valid(valid[1]), .tx_ready(ready[1]), .txd(txd[1]),
    .tx_busy(busy[1]), .tx_done(done[1]));

  uart_tx_bps #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .bps_tick(bps_tick), .tx_data(tx_data),
    .tx_valid(valid[2]), .tx_ready(ready[2]), .txd(txd[2]),
    .tx_busy(busy[2]), .tx_done(done[2]));

  uart_tx_bps #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .bps_tick(bps_tick), .tx_data(tx_data),
    .tx_valid(valid[3]), .tx_ready(ready[3]), .txd(txd[3]),
    .tx_busy(busy[3]), .tx_done(done[3]));

  initial forever #5 clk = ~clk;

  // tick every 4 clk, changed just after posedge so negedge sees the next edge's value
  initial forever begin
    @(posedge clk);
    #1;
    tc = (tc + 1) % 4;
    bps_tick = (tc == 3);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input int i, input logic [7:0] d, output int n);
    n = 0;
    exp_q.push_back(1'b0); n++;
    for (int b = 0; b < 8; b++) begin
      exp_q.push_back(d[b]); n++;
    end
    if (PEN[i]) begin
      exp_q.push_back((^d) ^ PODD[i]); n++;
    end
    exp_q.push_back(1'b1); n++;
    if (STOP2[i]) begin
      exp_q.push_back(1'b1); n++;
    end
  endtask

  task automatic frame(input int i, input logic [7:0] d, input bit at_tick,
                       input bit keep, input logic [7:0] nd, input bit wiggle);
    int   n, to, w;
    bit   at_acc, idle_ok, ok, dok, e;
    logic got;
    push_frame(i, d, n);
    to = 0;
    while (!(ready[i] && (!at_tick || bps_tick)) && to < 40) begin
      @(negedge clk);
      to++;
    end
    vec++;
    if (to >= 40) begin
      bad++;
      $display("FAIL ready_wait inst%0d: ready=%b after %0d clk, want 1", i, ready[i], to);
    end
    tx_data  = d;
    valid[i] = 1'b1;
    at_acc   = bps_tick;
    @(negedge clk);
    if (!keep) valid[i] = 1'b0;
    vec++;
    if (busy[i] !== 1'b1 || ready[i] !== 1'b0 || txd[i] !== 1'b1) begin
      bad++;
      $display("FAIL accept inst%0d: busy=%b ready=%b txd=%b, want 1 0 1",
               i, busy[i], ready[i], txd[i]);
    end
    w = 1;
    idle_ok = 1'b1;
    while (!bps_tick && w < 10) begin
      @(negedge clk);
      w++;
      if (txd[i] !== 1'b1) idle_ok = 1'b0;
    end
    vec++;
    if (w >= 10 || !idle_ok) begin
      bad++;
      $display("FAIL sync inst%0d: waited %0d clk, line idle=%0d, want <10 and 1", i, w, idle_ok);
    end
    if (at_acc) begin
      vec++;
      if (w != 4) begin
        bad++;
        $display("FAIL tick_in_accept inst%0d: start tick after %0d clk, want 4", i, w);
      end
    end
    for (int k = 0; k < n; k++) begin
      e   = exp_q.pop_front();
      ok  = 1'b1;
      dok = 1'b1;
      got = e;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (wiggle) tx_data = 8'($urandom);
        if (txd[i] !== e) begin
          ok  = 1'b0;
          got = txd[i];
        end
        if (done[i] !== ((k == n - 1) && (c == 3))) dok = 1'b0;
        if (keep && k == n - 1 && c == 3) tx_data = nd;
      end
      vec++;
      if (!ok || !dok) begin
        bad++;
        $display("FAIL bit%0d inst%0d data=%h: txd=%b done_ok=%0d, want txd=%b for 4 clk",
                 k, i, d, got, dok, e);
      end
    end
    @(negedge clk);
    vec++;
    if (ready[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
      bad++;
      $display("FAIL frame_end inst%0d: ready=%b busy=%b done=%b, want 1 0 0",
               i, ready[i], busy[i], done[i]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if (txd !== 4'hF || ready !== 4'hF || busy !== 4'h0 || done !== 4'h0) begin
      bad++;
      $display("FAIL reset: txd=%b ready=%b busy=%b done=%b, want 1111 1111 0000 0000",
               txd, ready, busy, done);
    end
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    frame(0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_parity;
    frame(1, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0);
    frame(2, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0);
    frame(1, 8'hC1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_tick_accept;
    frame(0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid;
    int to;
    tx_data  = 8'hF7;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    to = 0;
    while (txd[0] !== 1'b0 && to < 20) begin
      @(negedge clk);
      to++;
    end
    repeat (17) @(negedge clk);
    vec++;
    if (txd[0] !== 1'b0 || busy[0] !== 1'b1 || to >= 20) begin
      bad++;
      $display("FAIL mid_bit3: txd=%b busy=%b, want 0 1", txd[0], busy[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    vec++;
    if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1 || done[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: txd=%b busy=%b ready=%b done=%b, want 1 0 1 0",
               txd[0], busy[0], ready[0], done[0]);
    end
    @(negedge clk);
    frame(0, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    frame(3, 8'hFF, 1'b0, 1'b1, 8'h81, 1'b0);
    frame(3, 8'h81, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_busy_ignore;
    frame(0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_tick_accept;
    test_reset_mid;
    test_back_to_back;
    test_busy_ignore;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
